// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter among NREQ sources.
// Optional GRAY_PARITY_EN adds a registered parity bit of the Gray word.
module gray_conv_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 5,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_gray,
   output logic [WIDTH-1:0]      out_bin,
`ifdef GRAY_PARITY_EN
   output logic                  out_parity,
`endif
   output logic [IDW-1:0]        out_id
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [IDW-1:0]   ptr;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_id;
   logic [WIDTH-1:0] gnt_word;
   logic [WIDTH-1:0] gnt_gray;
   logic             found;
   logic             load;
   logic             clear;

   // search from ptr, wrapping modulo NREQ; first valid wins
   always_comb begin
      int idx;
      gnt      = '0;
      gnt_id   = '0;
      gnt_word = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
            gnt_word = req_data[idx*WIDTH +: WIDTH];
         end
      end
   end

   assign gnt_gray = gnt_word ^ (gnt_word >> 1);

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      clear     = 1'b0;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (!rst) begin
               req_ready = gnt;
            end
            if (found && !rst) begin
               load    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_valid && out_ready) begin
               clear   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_gray  <= '0;
         out_bin   <= '0;
         out_id    <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            out_valid <= 1'b1;
            out_gray  <= gnt_gray;
            out_bin   <= gnt_word;
            out_id    <= gnt_id;
         end
         if (clear) begin
            out_valid <= 1'b0;
            ptr       <= (out_id == IDW'(NREQ-1)) ? '0 : out_id + IDW'(1);
         end
      end
   end

`ifdef GRAY_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_parity <= 1'b0;
      end else if (load) begin
         out_parity <= ^gnt_gray;
      end
   end
`endif

   always_comb begin
      assert ($onehot0(req_ready));
   end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter with directed vectors.
// Expected results are queued at grant time and checked on acceptance.
module tb_gray_conv_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 5;
   localparam int IDW   = 2;

   typedef struct packed {
      logic [WIDTH-1:0] gray;
      logic [WIDTH-1:0] bin;
      logic [IDW-1:0]   id;
      logic             par;
   } exp_t;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_gray;
   logic [WIDTH-1:0]      out_bin;
   logic [IDW-1:0]        out_id;
   logic                  par_obs;
`ifdef GRAY_PARITY_EN
   logic                  out_parity;
   assign par_obs = out_parity;
`else
   assign par_obs = 1'b0;
`endif

   exp_t sb[$];
   int   ntests = 0;
   int   nfail  = 0;

   gray_conv_arbiter #(
      .NREQ (NREQ),
      .WIDTH(WIDTH),
      .IDW  (IDW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_gray (out_gray),
      .out_bin  (out_bin),
`ifdef GRAY_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_id   (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] b,
                       input logic [IDW-1:0] id, input logic p);
      exp_t e;
      e.gray = g;
      e.bin  = b;
      e.id   = id;
`ifdef GRAY_PARITY_EN
      e.par  = p;
`else
      e.par  = 1'b0;
      if (p) e.par = 1'b0;
`endif
      sb.push_back(e);
   endtask

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      req_data[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // wait (bounded) for a grant and compare it to the expected one-hot
   task automatic grant_check(input logic [NREQ-1:0] exp, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(req_ready), 32'(exp));
   endtask

   // monitor: every accepted output is matched against the queue head
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL sb_unexpected: got id %0d with empty queue", out_id);
         end else begin
            e = sb.pop_front();
            chk("sb_gray", 32'(out_gray), 32'(e.gray));
            chk("sb_bin", 32'(out_bin), 32'(e.bin));
            chk("sb_id", 32'(out_id), 32'(e.id));
            chk("sb_par", 32'(par_obs), 32'(e.par));
         end
      end
   end

   initial begin
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_data  = '0;
      out_ready = 1'b0;
      set_data(0, 5'd3);
      set_data(1, 5'd7);

      // reset: no grants even with requests pending
      repeat (2) begin
         @(negedge clk);
         chk("rst_ready", 32'(req_ready), 32'h0);
         chk("rst_valid", 32'(out_valid), 32'h0);
      end
      step();
      rst       = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("rst_gray", 32'(out_gray), 32'h0);
      chk("rst_bin", 32'(out_bin), 32'h0);
      chk("rst_id", 32'(out_id), 32'h0);
      chk("rst_par", 32'(par_obs), 32'h0);
      chk("idle_ready", 32'(req_ready), 32'h0);

      // single request then backpressure
      step();
      req_valid = 4'b0001;
      set_data(0, 5'b10110);
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'b0001);
      push(5'b11101, 5'b10110, 2'd0, 1'b0);
      step();
      req_valid = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'h1);
         chk("bp_gray", 32'(out_gray), 32'b11101);
         chk("bp_bin", 32'(out_bin), 32'b10110);
         chk("bp_id", 32'(out_id), 32'h0);
         chk("bp_ready", 32'(req_ready), 32'h0);
         if (c < 4) step();
      end
      step();
      out_ready = 1'b1;
      req_valid = 4'b0011;
      set_data(1, 5'b00011);
      step();
      @(negedge clk);
      chk("accept_valid", 32'(out_valid), 32'h0);
      chk("ptr1_grant", 32'(req_ready), 32'b0010);
      push(5'b00010, 5'b00011, 2'd1, 1'b1);
      step();
      req_valid = '0;

      // round robin from ptr=0
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_data(0, 5'd0);
      set_data(1, 5'd31);
      set_data(2, 5'd8);
      set_data(3, 5'd1);
      push(5'b00000, 5'd0, 2'd0, 1'b0);
      push(5'b10000, 5'd31, 2'd1, 1'b1);
      push(5'b01100, 5'd8, 2'd2, 1'b0);
      push(5'b00001, 5'd1, 2'd3, 1'b1);
      push(5'b00000, 5'd0, 2'd0, 1'b0);
      req_valid = 4'b1111;
      grant_check(4'b0001, "rr_g0");
      step();
      grant_check(4'b0010, "rr_g1");
      step();
      grant_check(4'b0100, "rr_g2");
      step();
      grant_check(4'b1000, "rr_g3");
      step();
      grant_check(4'b0001, "rr_g4");
      step();
      req_valid = '0;

      // pointer wrap: serve 2 to set ptr=3, then 3 before 0
      set_data(2, 5'b00111);
      set_data(3, 5'b11000);
      set_data(0, 5'b01010);
      push(5'b00100, 5'b00111, 2'd2, 1'b1);
      push(5'b10100, 5'b11000, 2'd3, 1'b0);
      push(5'b01111, 5'b01010, 2'd0, 1'b0);
      step();
      req_valid = 4'b0100;
      grant_check(4'b0100, "wrap_g2");
      step();
      req_valid = 4'b1001;
      grant_check(4'b1000, "wrap_g3");
      step();
      grant_check(4'b0001, "wrap_g0");
      step();
      req_valid = '0;

      // reset while holding a result from requester 2
      step();
      out_ready = 1'b0;
      req_valid = 4'b0100;
      set_data(2, 5'b10101);
      grant_check(4'b0100, "mid_g2");
      step();
      @(negedge clk);
      chk("mid_hold_id", 32'(out_id), 32'h2);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(req_ready), 32'h0);
      step();
      rst       = 1'b0;
      out_ready = 1'b1;
      set_data(2, 5'b01001);
      @(negedge clk);
      chk("mid_valid", 32'(out_valid), 32'h0);
      chk("mid_gray", 32'(out_gray), 32'h0);
      chk("mid_bin", 32'(out_bin), 32'h0);
      chk("mid_id", 32'(out_id), 32'h0);
      chk("mid_regrant", 32'(req_ready), 32'b0100);
      push(5'b01101, 5'b01001, 2'd2, 1'b1);
      step();
      req_valid = '0;

      // data changes after transfer must not leak into the result
      step();
      out_ready = 1'b0;
      req_valid = 4'b0001;
      set_data(0, 5'b11111);
      push(5'b10000, 5'b11111, 2'd0, 1'b1);
      grant_check(4'b0001, "cap_g0");
      step();
      req_valid = '0;
      set_data(0, 5'b00000);
      @(negedge clk);
      chk("cap_gray", 32'(out_gray), 32'b10000);
      chk("cap_bin", 32'(out_bin), 32'b11111);
      step();
      out_ready = 1'b1;
      repeat (4) step();

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
